// File: rtl/sram_access_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_access_controller: splits 32-bit MEM-stage accesses into two 16-bit   |
// | asynchronous SRAM transfers (low, high) plus fixed wait padding.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sram_access_controller #(
  parameter logic [31:0] BASE_ADDR     = 32'd1024,
  parameter int          ACCESS_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_OUT,
  output logic        SRAM_DQ_OE,
  input  logic [15:0] SRAM_DQ_IN,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST =
      CNT_W'((ACCESS_CYCLES > 3) ? (ACCESS_CYCLES - 4) : 0);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             is_write;
  logic [16:0]      word_addr;
  logic [15:0]      wdata_hi;
  logic [15:0]      rd_lo;
  logic [15:0]      rd_hi;
  logic [16:0]      word_addr_next;

  // Out-of-range addresses wrap modulo the 2^17-word SRAM.
  assign word_addr_next = 17'((address - BASE_ADDR) >> 2);

  assign ready = ((state == IDLE) && !(read_en || write_en)) || (state == DONE);

  // Strobes are registered: each transition loads the values for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      is_write    <= 1'b0;
      word_addr   <= '0;
      wdata_hi    <= '0;
      rd_lo       <= '0;
      rd_hi       <= '0;
      readData    <= '0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_OUT <= '0;
      SRAM_DQ_OE  <= 1'b0;
      SRAM_WE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_CE_N   <= 1'b1;
      SRAM_UB_N   <= 1'b1;
      SRAM_LB_N   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (read_en || write_en) begin
            is_write    <= write_en;
            word_addr   <= word_addr_next;
            wdata_hi    <= writeData[31:16];
            SRAM_ADDR   <= {word_addr_next, 1'b0};
            SRAM_DQ_OUT <= writeData[15:0];
            SRAM_DQ_OE  <= write_en;
            SRAM_WE_N   <= ~write_en;
            SRAM_OE_N   <= write_en;
            SRAM_CE_N   <= 1'b0;
            SRAM_UB_N   <= 1'b0;
            SRAM_LB_N   <= 1'b0;
            state       <= LOW;
          end
        end
        LOW: begin
          if (!is_write) rd_lo <= SRAM_DQ_IN;
          SRAM_ADDR   <= {word_addr, 1'b1};
          SRAM_DQ_OUT <= wdata_hi;
          state       <= HIGH;
        end
        HIGH: begin
          if (!is_write) rd_hi <= SRAM_DQ_IN;
          SRAM_DQ_OE <= 1'b0;
          SRAM_WE_N  <= 1'b1;
          SRAM_OE_N  <= 1'b1;
          SRAM_UB_N  <= 1'b1;
          SRAM_LB_N  <= 1'b1;
          wait_cnt   <= '0;
          if (ACCESS_CYCLES == 3) begin
            SRAM_CE_N <= 1'b1;
            if (!is_write) readData <= {SRAM_DQ_IN, rd_lo};
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (wait_cnt == WAIT_LAST) begin
            SRAM_CE_N <= 1'b1;
            if (!is_write) readData <= {rd_hi, rd_lo};
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_access_controller.sv
`default_nettype none
// Scoreboard bench for sram_access_controller: stimulus queues expected bus
// transfers and completions; a negedge monitor pops and compares them.
module tb_sram_access_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic [31:0] readData;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_OUT;
  logic        SRAM_DQ_OE;
  logic [15:0] SRAM_DQ_IN = '0;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [17:0] addr;
    logic        wr;
    logic [15:0] dq;
  } bus_t;

  typedef struct {
    logic [31:0] rd;
    int          lat;
  } done_t;

  bus_t  bus_q[$];
  done_t done_q[$];

  logic [15:0] mem [logic [17:0]];

  sram_access_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(6)) dut (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
    .address(address), .writeData(writeData), .readData(readData), .ready(ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_DQ_IN(SRAM_DQ_IN), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: write on strobe, read data driven mid-cycle.
  always @(posedge clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR] = SRAM_DQ_OUT;
  end

  always @(negedge clk) begin
    if (!SRAM_CE_N && !SRAM_OE_N && mem.exists(SRAM_ADDR)) SRAM_DQ_IN = mem[SRAM_ADDR];
    else SRAM_DQ_IN = 16'h0000;
  end

  // Monitor
  int          low_cnt = 0;
  logic [31:0] last_rd = '0;
  logic        chk_zero = 1'b0;

  always @(negedge clk) begin
    bus_t  b;
    done_t d;
    if (!SRAM_CE_N && (!SRAM_WE_N || !SRAM_OE_N)) begin
      compared++;
      if (bus_q.size() == 0) begin
        mismatched++;
        $display("FAIL bus_unexpected: addr=%h we_n=%b oe_n=%b, no transfer expected",
                 SRAM_ADDR, SRAM_WE_N, SRAM_OE_N);
      end else begin
        b = bus_q.pop_front();
        if (SRAM_ADDR !== b.addr || SRAM_WE_N !== ~b.wr || SRAM_OE_N !== b.wr ||
            SRAM_DQ_OE !== b.wr || SRAM_UB_N !== 1'b0 || SRAM_LB_N !== 1'b0 ||
            (b.wr && SRAM_DQ_OUT !== b.dq)) begin
          mismatched++;
          $display("FAIL bus_xfer: got addr=%h we_n=%b oe_n=%b oe=%b ub=%b lb=%b dq=%h, want addr=%h we_n=%b oe_n=%b oe=%b ub=0 lb=0 dq=%h",
                   SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_OE, SRAM_UB_N, SRAM_LB_N,
                   SRAM_DQ_OUT, b.addr, ~b.wr, b.wr, b.wr, b.dq);
        end
      end
    end

    if (rst) begin
      low_cnt  = 0;
      last_rd  = '0;
      chk_zero = 1'b1;
    end else if (!ready) begin
      low_cnt++;
    end else if (low_cnt > 0) begin
      compared++;
      if (done_q.size() == 0) begin
        mismatched++;
        $display("FAIL done_unexpected: completion after %0d frozen cycles, none expected", low_cnt);
      end else begin
        d = done_q.pop_front();
        if (low_cnt != d.lat || readData !== d.rd || SRAM_CE_N !== 1'b1 ||
            SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1 || SRAM_DQ_OE !== 1'b0) begin
          mismatched++;
          $display("FAIL done: got frozen=%0d rd=%h ce_n=%b we_n=%b oe_n=%b oe=%b, want frozen=%0d rd=%h ce_n=1 we_n=1 oe_n=1 oe=0",
                   low_cnt, readData, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_OE, d.lat, d.rd);
        end
        last_rd = d.rd;
      end
      low_cnt  = 0;
      chk_zero = 1'b0;
    end else begin
      compared++;
      if (SRAM_CE_N !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1 ||
          SRAM_UB_N !== 1'b1 || SRAM_LB_N !== 1'b1 || SRAM_DQ_OE !== 1'b0 ||
          readData !== last_rd ||
          (chk_zero && (SRAM_ADDR !== 18'h0 || SRAM_DQ_OUT !== 16'h0))) begin
        mismatched++;
        $display("FAIL idle: got ce_n=%b we_n=%b oe_n=%b ub=%b lb=%b oe=%b rd=%h addr=%h dq=%h, want strobes=1 oe=0 rd=%h%s",
                 SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_OE,
                 readData, SRAM_ADDR, SRAM_DQ_OUT, last_rd, chk_zero ? " addr=0 dq=0" : "");
      end
    end
  end

  // Stimulus helpers
  task automatic push_bus(input logic [17:0] a, input logic wr, input logic [15:0] dq);
    bus_t b;
    b.addr = a; b.wr = wr; b.dq = dq;
    bus_q.push_back(b);
  endtask

  task automatic push_done(input logic [31:0] rd);
    done_t d;
    d.rd = rd; d.lat = 6;
    done_q.push_back(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after DONE with requests dropped.
  task automatic access(input logic re, input logic we, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    read_en = re; write_en = we; address = a; writeData = wd;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      compared++;
      mismatched++;
      $display("FAIL access_timeout: ready=%b after %0d cycles, want ready=1", ready, n);
    end
    @(posedge clk);
    #1;
    read_en = 1'b0; write_en = 1'b0;
  endtask

  initial begin
    mem[18'd4] = 16'h5678;
    mem[18'd5] = 16'h1234;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(4);

    // Write 0xDEADBEEF to word 0
    push_bus(18'h00000, 1'b1, 16'hBEEF);
    push_bus(18'h00001, 1'b1, 16'hDEAD);
    push_done(32'h0000_0000);
    access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF);
    idle(2);

    // Read preloaded word at SRAM half-words 4/5
    push_bus(18'h00004, 1'b0, 16'h0000);
    push_bus(18'h00005, 1'b0, 16'h0000);
    push_done(32'h1234_5678);
    access(1'b1, 1'b0, 32'd1032, 32'h0);

    // readData must hold across a write
    push_bus(18'h00002, 1'b1, 16'hF00D);
    push_bus(18'h00003, 1'b1, 16'hCAFE);
    push_done(32'h1234_5678);
    access(1'b0, 1'b1, 32'd1028, 32'hCAFE_F00D);
    idle(1);

    // Back-to-back write then read of the same word
    push_bus(18'h00000, 1'b1, 16'hBEEF);
    push_bus(18'h00001, 1'b1, 16'hDEAD);
    push_done(32'h1234_5678);
    access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF);
    push_bus(18'h00000, 1'b0, 16'h0000);
    push_bus(18'h00001, 1'b0, 16'h0000);
    push_done(32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'd1024, 32'h0);
    idle(2);

    // Both requests set below BASE_ADDR: write wins, address wraps
    push_bus(18'h3FFFE, 1'b1, 16'hC0DE);
    push_bus(18'h3FFFF, 1'b1, 16'h0BAD);
    push_done(32'hDEAD_BEEF);
    access(1'b1, 1'b1, 32'd1020, 32'h0BAD_C0DE);
    push_bus(18'h3FFFE, 1'b0, 16'h0000);
    push_bus(18'h3FFFF, 1'b0, 16'h0000);
    push_done(32'h0BAD_C0DE);
    access(1'b1, 1'b0, 32'd1020, 32'h0);
    idle(2);

    // Reset asserted during HIGH of a read
    push_bus(18'h00004, 1'b0, 16'h0000);
    push_bus(18'h00005, 1'b0, 16'h0000);
    read_en = 1'b1; address = 32'd1032;
    idle(2);
    rst = 1'b1; read_en = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(2);
    push_bus(18'h00004, 1'b0, 16'h0000);
    push_bus(18'h00005, 1'b0, 16'h0000);
    push_done(32'h1234_5678);
    access(1'b1, 1'b0, 32'd1032, 32'h0);
    idle(4);

    compared++;
    if (bus_q.size() != 0 || done_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: bus_q=%0d done_q=%0d pending, want 0 and 0", bus_q.size(), done_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
